bomb_countdown: RTL and testbench
=================================

Name: bomb_countdown

Overview:
- Downstream consumer of the one-second/half-second timer in the bomb controller.
- Holds the remaining fuse time as BCD MM:SS and drives the timer's enable/clear controls.
- Decrements once per second_elapsed, toggles the blink indicator on half_second_elapsed, and raises a warning near the end.
- Terminates in EXPLODED at 00:00 or DEFUSED on disarm. Feeds the display driver and status LEDs.

Parameters:
- WARN_SECONDS, 10: warning asserted while ARMED and remaining time < WARN_SECONDS; legal range 0..59.

Ports:
- clk  input  1  system clock
- sync_reset  input  1  synchronous, active-high reset
- load  input  1  pulse; capture load_digits as the new fuse time
- load_digits  input  16  BCD {min_tens, min_units, sec_tens, sec_units}
- arm  input  1  pulse; start countdown
- disarm  input  1  pulse; defuse while armed
- second_elapsed  input  1  from timer; one-cycle pulse per second
- half_second_elapsed  input  1  from timer; one-cycle pulse per half second
- timer_enable  output  1  to timer enable
- timer_clear  output  1  to timer clear
- count_digits  output  16  current BCD MM:SS, same packing as load_digits
- blink  output  1  display blink phase
- warning  output  1  final-seconds indicator
- armed  output  1  state == ARMED
- defused  output  1  state == DEFUSED
- exploded  output  1  state == EXPLODED
- load_error  output  1  one-cycle pulse; rejected load

Behaviour:
- Reset: sync_reset is synchronous and active-high, sampled on rising clk. It forces IDLE, count_digits=16'h0000, blink=0, load_error=0. Reset mid-countdown aborts immediately; the next cycle is IDLE.
- States: IDLE, ARMED, DEFUSED, EXPLODED. armed, defused and exploded decode the state register.
- IDLE:
  - load with a valid value: count_digits <= load_digits at the next edge.
  - Valid means every digit <= 9 and sec_tens <= 5.
  - Invalid load: count is unchanged and load_error pulses high for one cycle, registered (the cycle after load).
  - arm with count != 0 -> ARMED. arm with count == 0 is ignored.
  - load and arm in the same cycle: load is processed and arm is ignored.
- Timer controls (combinational from state and inputs):
  - timer_enable = (state == ARMED).
  - timer_clear = 1 in IDLE, DEFUSED and EXPLODED; 0 in ARMED. The timer therefore starts from 0 on the first ARMED cycle.
- ARMED:
  - load and arm are ignored.
  - On second_elapsed, decrement BCD with borrow:
    - sec_units>0: units-1.
    - else sec_units=9, then sec_tens>0: tens-1.
    - else sec_tens=5 and borrow into minutes (min_units 0 -> 9 with min_tens-1).
  - If count == 00:01 at the second_elapsed pulse: count <= 00:00 and state <= EXPLODED at the same edge.
  - disarm -> DEFUSED; count freezes at its current value. disarm has priority over a simultaneous second_elapsed, including the final 00:01 -> 00:00 step.
- blink:
  - ARMED: toggles on each half_second_elapsed.
  - Cleared to 0 on the IDLE->ARMED transition.
  - IDLE and DEFUSED: 0.
  - EXPLODED: forced 1.
- warning: combinational. It is 1 when all of the following hold:
  - state == ARMED
  - min digits == 0
  - (sec_tens*10 + sec_units) < WARN_SECONDS
- Arithmetic: count never wraps below 00:00. second_elapsed is ignored outside ARMED.
- DEFUSED and EXPLODED are terminal. All inputs except sync_reset are ignored and count holds.
- Timing: all state and count updates are visible the cycle after the triggering pulse. No other latency.

Test Plan:
1. Reset, load 16'h0103, arm, then 3 second_elapsed pulses -> count 01:03 -> 01:02 -> 01:01 -> 01:00; armed=1; timer_clear low from the first ARMED cycle.
2. Load 16'h0100, arm, one second_elapsed -> count 00:59; with WARN_SECONDS=10, warning stays 0 until count 00:09 and is 1 at 00:09.
3. Load 16'h0002, arm, 2 second_elapsed -> 00:01 then 00:00 with exploded=1, blink=1, timer_enable=0; further pulses, arm and disarm leave count at 00:00.
4. Load 16'h0001, arm, then assert disarm and second_elapsed in the same cycle -> defused=1, count stays 00:01, exploded stays 0.
5. Load 16'h0070 (sec_tens=7) -> load_error pulses for exactly one cycle and count is unchanged. Arm with count 00:00 -> state stays IDLE.
6. While ARMED at 00:30, pulse half_second_elapsed 3 times -> blink reads 1, 0, 1. Assert sync_reset -> next cycle IDLE, count 0000, blink 0, timer_clear 1.

Source files
------------

// File: rtl/bomb_countdown.sv
// Bomb fuse countdown: holds the remaining time as BCD MM:SS, drives the
// one-second timer controls, and walks IDLE -> ARMED -> DEFUSED/EXPLODED.
module bomb_countdown #(
  parameter int unsigned WARN_SECONDS = 10
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        load,
  input  logic [15:0] load_digits,
  input  logic        arm,
  input  logic        disarm,
  input  logic        second_elapsed,
  input  logic        half_second_elapsed,
  output logic        timer_enable,
  output logic        timer_clear,
  output logic [15:0] count_digits,
  output logic        blink,
  output logic        warning,
  output logic        armed,
  output logic        defused,
  output logic        exploded,
  output logic        load_error
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DEFUSED,
    EXPLODED
  } state_t;

  localparam logic [6:0] WARN_LIMIT = 7'(WARN_SECONDS);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        blink_q;
  logic        blink_d;
  logic        load_error_q;
  logic        load_error_d;

  logic        load_valid;
  logic        count_is_zero;
  logic        count_is_one;
  logic [6:0]  seconds_value;
  logic [15:0] count_decremented;

  // One-second BCD decrement with borrow through seconds and minutes.
  // Callers never pass 00:00, so the minute borrow cannot underflow.
  function automatic logic [15:0] bcd_decrement(input logic [15:0] value);
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    min_tens  = value[15:12];
    min_units = value[11:8];
    sec_tens  = value[7:4];
    sec_units = value[3:0];
    if (sec_units != 4'd0) begin
      sec_units = sec_units - 4'd1;
    end else begin
      sec_units = 4'd9;
      if (sec_tens != 4'd0) begin
        sec_tens = sec_tens - 4'd1;
      end else begin
        sec_tens = 4'd5;
        if (min_units != 4'd0) begin
          min_units = min_units - 4'd1;
        end else begin
          min_units = 4'd9;
          min_tens  = min_tens - 4'd1;
        end
      end
    end
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  // Decode helpers: load validity, terminal-count detection and the
  // seconds field as a binary number for the warning threshold.
  always_comb begin
    load_valid = (load_digits[15:12] <= 4'd9) &&
                 (load_digits[11:8]  <= 4'd9) &&
                 (load_digits[7:4]   <= 4'd5) &&
                 (load_digits[3:0]   <= 4'd9);
    count_is_zero     = (count_q == 16'h0000);
    count_is_one      = (count_q == 16'h0001);
    seconds_value     = ({3'b000, count_q[7:4]} * 7'd10) + {3'b000, count_q[3:0]};
    count_decremented = bcd_decrement(count_q);
  end

  // Next-state, next-count and blink/load-error logic for every state.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    blink_d      = blink_q;
    load_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        blink_d = 1'b0;
        if (load) begin
          // A load wins over a simultaneous arm; the arm is dropped.
          if (load_valid) begin
            count_d = load_digits;
          end else begin
            load_error_d = 1'b1;
          end
        end else if (arm && !count_is_zero) begin
          state_d = ARMED;
          blink_d = 1'b0;
        end
      end

      ARMED: begin
        if (half_second_elapsed) begin
          blink_d = ~blink_q;
        end
        if (disarm) begin
          // Disarm beats the tick, even the one that would reach 00:00.
          state_d = DEFUSED;
          blink_d = 1'b0;
        end else if (second_elapsed) begin
          if (count_is_one) begin
            count_d = 16'h0000;
            state_d = EXPLODED;
            blink_d = 1'b1;
          end else if (!count_is_zero) begin
            count_d = count_decremented;
          end
        end
      end

      DEFUSED: begin
        blink_d = 1'b0;
      end

      EXPLODED: begin
        blink_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        count_d = 16'h0000;
        blink_d = 1'b0;
      end
    endcase
  end

  // State, count, blink and load-error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q      <= IDLE;
      count_q      <= 16'h0000;
      blink_q      <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      blink_q      <= blink_d;
      load_error_q <= load_error_d;
    end
  end

  // Output decode: timer controls, status flags and the warning window.
  always_comb begin
    timer_enable = (state_q == ARMED);
    timer_clear  = (state_q != ARMED);
    armed        = (state_q == ARMED);
    defused      = (state_q == DEFUSED);
    exploded     = (state_q == EXPLODED);
    count_digits = count_q;
    blink        = blink_q;
    load_error   = load_error_q;
    warning      = (state_q == ARMED) &&
                   (count_q[15:8] == 8'h00) &&
                   (seconds_value < WARN_LIMIT);
  end

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown with hand-computed expected values.
module tb_bomb_countdown;

  logic        clk;
  logic        sync_reset;
  logic        load;
  logic [15:0] load_digits;
  logic        arm;
  logic        disarm;
  logic        second_elapsed;
  logic        half_second_elapsed;
  logic        timer_enable;
  logic        timer_clear;
  logic [15:0] count_digits;
  logic        blink;
  logic        warning;
  logic        armed;
  logic        defused;
  logic        exploded;
  logic        load_error;

  int checks_total;
  int checks_passed;

  bomb_countdown #(.WARN_SECONDS(10)) dut (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .load                (load),
    .load_digits         (load_digits),
    .arm                 (arm),
    .disarm              (disarm),
    .second_elapsed      (second_elapsed),
    .half_second_elapsed (half_second_elapsed),
    .timer_enable        (timer_enable),
    .timer_clear         (timer_clear),
    .count_digits        (count_digits),
    .blink               (blink),
    .warning             (warning),
    .armed               (armed),
    .defused             (defused),
    .exploded            (exploded),
    .load_error          (load_error)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts a comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 ns after the capturing edge.
  task automatic applyStimulus(input logic ld, input logic [15:0] digits,
                               input logic ar, input logic dis,
                               input logic sec, input logic half);
    load                = ld;
    load_digits         = digits;
    arm                 = ar;
    disarm              = dis;
    second_elapsed      = sec;
    half_second_elapsed = half;
    @(posedge clk);
    #1;
    load                = 1'b0;
    load_digits         = 16'h0000;
    arm                 = 1'b0;
    disarm              = 1'b0;
    second_elapsed      = 1'b0;
    half_second_elapsed = 1'b0;
  endtask

  task automatic doReset();
    sync_reset = 1'b1;
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
  endtask

  task automatic tick();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic loadValue(input logic [15:0] digits);
    applyStimulus(1'b1, digits, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic armNow();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Stimulus sequence following the test plan plus a few boundary cases.
  initial begin
    checks_total        = 0;
    checks_passed       = 0;
    sync_reset          = 1'b0;
    load                = 1'b0;
    load_digits         = 16'h0000;
    arm                 = 1'b0;
    disarm              = 1'b0;
    second_elapsed      = 1'b0;
    half_second_elapsed = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_count", count_digits, 16'h0000);
    checkOutput("rst_armed", 16'(armed), 16'h0000);
    checkOutput("rst_blink", 16'(blink), 16'h0000);
    checkOutput("rst_lderr", 16'(load_error), 16'h0000);
    checkOutput("rst_tclear", 16'(timer_clear), 16'h0001);
    checkOutput("rst_tenable", 16'(timer_enable), 16'h0000);

    // 1: load 01:03, arm, three ticks
    loadValue(16'h0103);
    checkOutput("t1_load", count_digits, 16'h0103);
    checkOutput("t1_idle_clear", 16'(timer_clear), 16'h0001);
    armNow();
    checkOutput("t1_armed", 16'(armed), 16'h0001);
    checkOutput("t1_tclear", 16'(timer_clear), 16'h0000);
    checkOutput("t1_tenable", 16'(timer_enable), 16'h0001);
    tick();
    checkOutput("t1_c0102", count_digits, 16'h0102);
    tick();
    checkOutput("t1_c0101", count_digits, 16'h0101);
    tick();
    checkOutput("t1_c0100", count_digits, 16'h0100);
    checkOutput("t1_armed_end", 16'(armed), 16'h0001);
    checkOutput("t1_warn", 16'(warning), 16'h0000);

    // 2: minute borrow and warning threshold
    doReset();
    loadValue(16'h0100);
    armNow();
    tick();
    checkOutput("t2_c0059", count_digits, 16'h0059);
    checkOutput("t2_warn59", 16'(warning), 16'h0000);
    for (int i = 0; i < 49; i++) begin
      tick();
    end
    checkOutput("t2_c0010", count_digits, 16'h0010);
    checkOutput("t2_warn10", 16'(warning), 16'h0000);
    tick();
    checkOutput("t2_c0009", count_digits, 16'h0009);
    checkOutput("t2_warn09", 16'(warning), 16'h0001);

    // Tens-of-minutes borrow: 10:00 -> 09:59
    doReset();
    loadValue(16'h1000);
    armNow();
    tick();
    checkOutput("bor_c0959", count_digits, 16'h0959);

    // 3: countdown to explosion, terminal state holds
    doReset();
    loadValue(16'h0002);
    armNow();
    tick();
    checkOutput("t3_c0001", count_digits, 16'h0001);
    checkOutput("t3_warn01", 16'(warning), 16'h0001);
    tick();
    checkOutput("t3_c0000", count_digits, 16'h0000);
    checkOutput("t3_exploded", 16'(exploded), 16'h0001);
    checkOutput("t3_blink", 16'(blink), 16'h0001);
    checkOutput("t3_tenable", 16'(timer_enable), 16'h0000);
    checkOutput("t3_tclear", 16'(timer_clear), 16'h0001);
    checkOutput("t3_warn_off", 16'(warning), 16'h0000);
    tick();
    armNow();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    loadValue(16'h0500);
    checkOutput("t3_hold_count", count_digits, 16'h0000);
    checkOutput("t3_hold_expl", 16'(exploded), 16'h0001);
    checkOutput("t3_hold_blink", 16'(blink), 16'h0001);

    // 4: disarm beats the final tick
    doReset();
    loadValue(16'h0001);
    armNow();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_defused", 16'(defused), 16'h0001);
    checkOutput("t4_count", count_digits, 16'h0001);
    checkOutput("t4_exploded", 16'(exploded), 16'h0000);
    checkOutput("t4_blink", 16'(blink), 16'h0000);
    tick();
    checkOutput("t4_hold", count_digits, 16'h0001);

    // 5: invalid load, arm at zero, load+arm together
    doReset();
    loadValue(16'h0070);
    checkOutput("t5_lderr_hi", 16'(load_error), 16'h0001);
    checkOutput("t5_count", count_digits, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_lderr_lo", 16'(load_error), 16'h0000);
    armNow();
    checkOutput("t5_arm_zero", 16'(armed), 16'h0000);
    applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_ldarm_cnt", count_digits, 16'h0005);
    checkOutput("t5_ldarm_st", 16'(armed), 16'h0000);
    loadValue(16'h0A00);
    checkOutput("t5_bad_min", 16'(load_error), 16'h0001);
    checkOutput("t5_bad_cnt", count_digits, 16'h0005);

    // 6: blink toggling, then reset mid-countdown
    doReset();
    loadValue(16'h0030);
    armNow();
    checkOutput("t6_blink0", 16'(blink), 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_blink1", 16'(blink), 16'h0001);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_blink2", 16'(blink), 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_blink3", 16'(blink), 16'h0001);
    checkOutput("t6_count", count_digits, 16'h0030);
    doReset();
    checkOutput("t6_rst_armed", 16'(armed), 16'h0000);
    checkOutput("t6_rst_count", count_digits, 16'h0000);
    checkOutput("t6_rst_blink", 16'(blink), 16'h0000);
    checkOutput("t6_rst_tclear", 16'(timer_clear), 16'h0001);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
